// File: rtl/pwm_capture_if.sv
// pwm_capture_if: signal bundle between a PWM capture block and its user.
//   i_en, i_pwm      : capture enable and raw (asynchronous) PWM input
//   o_dutyCycle      : recovered duty code, N bits
//   o_highCnt        : last measured high time, CNT_W bits
//   o_periodCnt      : last measured period, CNT_W bits
//   o_valid          : one-cycle pulse when the three results update
//   o_timeout        : no rising edge within 2*PERIOD_CLK_COUNT cycles
// master drives enable/input and reads results; slave is the capture block.
interface pwm_capture_if #(
  parameter int N     = 8,
  parameter int CNT_W = 22
);
  logic             i_en;
  logic             i_pwm;
  logic [N-1:0]     o_dutyCycle;
  logic [CNT_W-1:0] o_highCnt;
  logic [CNT_W-1:0] o_periodCnt;
  logic             o_valid;
  logic             o_timeout;

  modport master (output i_en, i_pwm,
                  input  o_dutyCycle, o_highCnt, o_periodCnt, o_valid, o_timeout);
  modport slave  (input  i_en, i_pwm,
                  output o_dutyCycle, o_highCnt, o_periodCnt, o_valid, o_timeout);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input and
// recovers the duty code high_time / (PERIOD_CLK_COUNT >> N), saturated to
// 2^N-1, with a serial restoring divider (one quotient bit per cycle).
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)    : i_en, i_pwm in; o_dutyCycle, o_highCnt, o_periodCnt,
//                    o_valid, o_timeout out (see pwm_capture_if)
// Optional: define PWM_CAPTURE_GLITCH_FILTER_EN to require the synchronized
// input to be stable for FILTER_LEN (>= 2) cycles before it is accepted.
module pwm_capture #(
  parameter int N                = 8,
  parameter int PERIOD_CLK_COUNT = 2000000,
  parameter int CNT_W            = 22,
  parameter int FILTER_LEN       = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  pwm_capture_if.slave bus
);
  localparam int               STEP     = PERIOD_CLK_COUNT >> N;
  localparam int               IW       = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] TERM     = CNT_W'(2 * PERIOD_CLK_COUNT);
  localparam logic [CNT_W:0]   STEP_V   = (CNT_W + 1)'(STEP);
  localparam logic [N-1:0]     DUTY_MAX = '1;

  typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

  // ---------------- input path ----------------
  logic sync1, sync2, pin, pin_d, rise, fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) {sync2, sync1} <= 2'b00;
    else          {sync2, sync1} <= {sync1, bus.i_pwm};
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Accept a new level only once the last FILTER_LEN samples agree; both
  // edges pay the same delay so measured widths stay exact.
  logic [FILTER_LEN-1:0] hist;
  logic                  filt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist <= '0;
      filt <= 1'b0;
    end else begin
      hist <= {hist[FILTER_LEN-2:0], sync2};
      if (&hist)       filt <= 1'b1;
      else if (~|hist) filt <= 1'b0;
    end
  end
  assign pin = filt;
`else
  // FILTER_LEN only shapes the filtered build; it folds away here.
  assign pin = sync2 & (FILTER_LEN >= 0);
`endif

  assign rise = pin & ~pin_d;
  assign fall = ~pin & pin_d;

  // ---------------- measurement FSM ----------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt, hi_lat;
  logic             cnt_sat, cnt_start, latch_hi, close, tmo;

  assign cnt_sat = (cnt == TERM);

  always_comb begin
    state_d   = state_q;
    cnt_start = 1'b0;
    latch_hi  = 1'b0;
    close     = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      ARM:  if (rise) begin state_d = HIGH; cnt_start = 1'b1; end
      HIGH: if (fall) begin state_d = LOW; latch_hi = 1'b1; end
            else if (cnt_sat) begin state_d = ARM; tmo = 1'b1; end
      // A rise coinciding with terminal count wins over the timeout.
      LOW:  if (rise) begin state_d = HIGH; cnt_start = 1'b1; close = 1'b1; end
            else if (cnt_sat) begin state_d = ARM; tmo = 1'b1; end
      default: state_d = ARM;
    endcase
    if (!bus.i_en) begin
      state_d   = ARM;
      cnt_start = 1'b0;
      latch_hi  = 1'b0;
      close     = 1'b0;
      tmo       = 1'b0;
    end
  end

  // cnt restarts at 1 on the rise cycle, so at the falling-edge detect it
  // equals the high width and at the next rise it equals the period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARM;
      pin_d   <= 1'b0;
      cnt     <= '0;
      hi_lat  <= '0;
    end else begin
      state_q <= state_d;
      pin_d   <= pin;
      if (!bus.i_en)                      cnt <= '0;
      else if (cnt_start)                 cnt <= CNT_W'(1);
      else if (state_q != ARM && !cnt_sat) cnt <= cnt + 1'b1;
      if (latch_hi) hi_lat <= cnt;
    end
  end

  // ---------------- divider and results ----------------
  logic             busy;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] rem, quo, d_hi, d_per, rem_n, quo_n;
  logic [CNT_W:0]   trial, diff;
  logic             ge;

  // Dividend bits shift out of quo's MSB while quotient bits shift in.
  always_comb begin
    trial = {rem, quo[CNT_W-1]};
    diff  = trial - STEP_V;
    ge    = (trial >= STEP_V);
    rem_n = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    quo_n = {quo[CNT_W-2:0], ge};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy            <= 1'b0;
      idx             <= '0;
      rem             <= '0;
      quo             <= '0;
      d_hi            <= '0;
      d_per           <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_timeout   <= 1'b0;
      bus.o_dutyCycle <= '0;
      bus.o_highCnt   <= '0;
      bus.o_periodCnt <= '0;
    end else begin
      bus.o_valid <= 1'b0;
      if (!bus.i_en) begin
        busy          <= 1'b0;
        rem           <= '0;
        quo           <= '0;
        bus.o_timeout <= 1'b0;
      end else if (tmo) begin
        busy            <= 1'b0;
        bus.o_timeout   <= 1'b1;
        bus.o_valid     <= 1'b1;
        bus.o_dutyCycle <= pin ? DUTY_MAX : '0;
        bus.o_highCnt   <= '0;
        bus.o_periodCnt <= '0;
      end else begin
        if (rise) bus.o_timeout <= 1'b0;
        if (busy) begin
          rem <= rem_n;
          quo <= quo_n;
          idx <= idx - 1'b1;
          // Last quotient bit: publish in the same edge so o_valid lands
          // CNT_W+1 cycles after the closing rise.
          if (idx == IW'(1)) begin
            busy            <= 1'b0;
            bus.o_valid     <= 1'b1;
            bus.o_dutyCycle <= (quo_n > CNT_W'(DUTY_MAX)) ? DUTY_MAX : quo_n[N-1:0];
            bus.o_highCnt   <= d_hi;
            bus.o_periodCnt <= d_per;
          end
        end
        // Closing edge while busy is an overrun: dropped, counting restarts.
        if (close && !busy) begin
          busy  <= 1'b1;
          idx   <= IW'(CNT_W);
          rem   <= '0;
          quo   <= hi_lat;
          d_hi  <= hi_lat;
          d_per <= cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus for pwm_capture (N=4, PERIOD=160, STEP=10,
// CNT_W=9). An event-level model (edge timestamps + result queue) predicts
// every output each cycle; literal checks pin key values.
module tb_pwm_capture;
  localparam int N = 4, PER = 160, CNT_W = 9, FL = 4, STEP = PER >> N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_capture_if #(.N(N), .CNT_W(CNT_W)) bus ();

  pwm_capture #(.N(N), .PERIOD_CLK_COUNT(PER), .CNT_W(CNT_W), .FILTER_LEN(FL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int     n_chk = 0, n_err = 0, n_valid = 0;
  longint cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---- model: input as seen after two synchronizer flops ----
  logic m1, m2, mpin;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin m1 <= 1'b0; m2 <= 1'b0; end
    else begin m1 <= bus.i_pwm; m2 <= m1; end
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [FL-1:0] mh;
  logic          mf;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin mh <= '0; mf <= 1'b0; end
    else begin
      mh <= {mh[FL-2:0], m2};
      if (mh == '1) mf <= 1'b1; else if (mh == '0) mf <= 1'b0;
    end
  assign mpin = mf;
`else
  assign mpin = m2;
`endif

  typedef struct { longint due; int duty; int hi; int per; } res_t;
  res_t   pend[$];
  res_t   r;
  bit     armed, e_to, e_vld, prev_pin;
  longint t_rise, busy_end;
  int     m_hi, e_duty, e_hi, e_per, q;

  // One compare process: results due this cycle are applied, outputs are
  // checked, then this cycle's edges are turned into future expectations.
  always @(negedge clk) begin
    cyc++;
    e_vld = 1'b0;
    if (!rst_n) begin
      pend.delete();
      armed = 0; e_to = 0; prev_pin = 0; busy_end = -100;
      e_duty = 0; e_hi = 0; e_per = 0;
    end else begin
      while (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        e_vld = 1'b1; e_duty = r.duty; e_hi = r.hi; e_per = r.per;
      end
    end
    chk("valid",   bus.o_valid,     e_vld);
    chk("timeout", bus.o_timeout,   e_to);
    chk("duty",    bus.o_dutyCycle, e_duty);
    chk("high",    bus.o_highCnt,   e_hi);
    chk("period",  bus.o_periodCnt, e_per);
    if (bus.o_valid) n_valid++;
    if (rst_n) begin
      if (!bus.i_en) begin
        pend.delete(); armed = 0; e_to = 0; busy_end = -100;
      end else if (mpin && !prev_pin) begin
        e_to = 0;
        if (armed && cyc > busy_end) begin
          q = m_hi / STEP;
          pend.push_back('{cyc + CNT_W + 1, (q > 15) ? 15 : q, m_hi, int'(cyc - t_rise)});
          busy_end = cyc + CNT_W;
        end
        armed = 1; t_rise = cyc;
      end else if (!mpin && prev_pin && armed) begin
        m_hi = int'(cyc - t_rise);
      end else if (armed && cyc - t_rise >= 2 * PER) begin
        e_to = 1; armed = 0;
        pend.push_back('{cyc + 1, mpin ? 15 : 0, 0, 0});
      end
      prev_pin = mpin;
    end
  end

  // ---- stimulus ----
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic drive(input logic v, input int n);
    bus.i_pwm = v; tick(n);
  endtask
  task automatic lit(input string tag, input int d, input int h, input int p);
    chk({tag, "_duty"},   bus.o_dutyCycle, d);
    chk({tag, "_high"},   bus.o_highCnt,   h);
    chk({tag, "_period"}, bus.o_periodCnt, p);
  endtask

  int v0;
  initial begin
    rst_n = 1'b0; bus.i_en = 1'b1; bus.i_pwm = 1'b0;
    tick(3);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    lit("rst", 0, 0, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: period 160 / high 50; first rise only arms
    repeat (4) begin drive(1, 50); drive(0, 110); end
    bus.i_pwm = 1'b1;
    tick(11); chk("t1_early_valid", bus.o_valid, 0);
    tick(1);  chk("t1_lat_valid",   bus.o_valid, 1);
    lit("t1", 5, 50, 160);
    tick(38); drive(0, 110);
    chk("t1_nvalid", n_valid, 4);

    // 2: period 250 / high 170 saturates the code
    repeat (3) begin drive(1, 170); drive(0, 80); end
    bus.i_pwm = 1'b1; tick(12);
    lit("t2", 15, 170, 250);
    tick(38); drive(0, 110);

    // 3: stuck low
    v0 = n_valid;
    drive(0, 400);
    chk("t3_timeout", bus.o_timeout, 1);
    lit("t3", 0, 0, 0);
    chk("t3_nvalid", n_valid - v0, 1);
    bus.i_pwm = 1'b1; tick(3);
    chk("t3_clear", bus.o_timeout, 0);

    // 4: stuck high, counter saturates without wrapping
    v0 = n_valid;
    drive(1, 400);
    chk("t4_timeout", bus.o_timeout, 1);
    lit("t4", 15, 0, 0);
    chk("t4_nvalid", n_valid - v0, 1);

    // 5: reset mid-HIGH
    drive(0, 110);
    repeat (2) begin drive(1, 50); drive(0, 110); end
    drive(1, 20);
    rst_n = 1'b0; #1;
    chk("t5_valid0", bus.o_valid, 0);
    lit("t5_rst", 0, 0, 0);
    tick(3); rst_n = 1'b1;
    v0 = n_valid;
    drive(1, 30); drive(0, 110);
    chk("t5_no_early", n_valid - v0, 0);
    drive(1, 50);
    lit("t5", 3, 30, 140);
    chk("t5_nvalid", n_valid - v0, 1);
    drive(0, 110);

    // enable dropped mid-measurement: results hold, first rise after only arms
    drive(1, 20);
    bus.i_en = 1'b0; drive(1, 10);
    chk("en_timeout", bus.o_timeout, 0);
    lit("en_hold", 5, 50, 160);
    bus.i_en = 1'b1;
    v0 = n_valid;
    drive(1, 20); drive(0, 110); drive(1, 50); drive(0, 110);
    chk("en_arm_only", n_valid - v0, 0);

    // 6: 2-cycle glitch inside the low phase
    repeat (2) begin drive(1, 50); drive(0, 110); end
    drive(1, 50); drive(0, 48); drive(1, 2); drive(0, 60); drive(1, 20);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    lit("t6", 5, 50, 160);
`else
    lit("t6", 0, 2, 62);
`endif
    drive(1, 30); drive(0, 40);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
